// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes, registered result and flags,
// iterative shifts and an optional shift-add multiplier.
module alu_seq #(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             Negative,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam bit MUL_ON = (MUL_EN != 0);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_EQ  = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [3:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_out;
    logic                 r_zero;
    logic                 r_carry;
    logic                 r_ovf;
    logic                 r_neg;
    logic                 r_inReady;
    logic                 r_outValid;
    logic                 r_busy;

    logic [SHW-1:0]       w_shAmt;
    logic                 w_isShift;
    logic                 w_startBusy;
    logic [WIDTH:0]       w_addFull;
    logic [WIDTH:0]       w_subFull;
    logic [WIDTH-1:0]     w_scOut;
    logic                 w_scCarry;
    logic                 w_scOvf;
    logic [WIDTH:0]       w_mulSum;
    logic [2*WIDTH-1:0]   w_mulNext;
    logic [2*WIDTH-1:0]   w_stepAcc;
    logic                 w_stepCarry;
    logic [WIDTH-1:0]     w_finOut;
    logic                 w_finCarry;
    logic                 w_finOvf;

    assign w_shAmt     = B[SHW-1:0];
    assign w_isShift   = (control == OP_SHL) || (control == OP_SHR);
    assign w_startBusy = (w_isShift && (w_shAmt != '0)) || ((control == OP_MUL) && MUL_ON);
    assign w_addFull   = {1'b0, A} + {1'b0, B};
    assign w_subFull   = {1'b0, A} - {1'b0, B};

    // Results of operations that complete directly from IDLE; a zero-length shift passes A through.
    always_comb begin
        w_scOut   = '0;
        w_scCarry = 1'b0;
        w_scOvf   = 1'b0;
        case (control)
            OP_AND: w_scOut = A & B;
            OP_OR:  w_scOut = A | B;
            OP_ADD: begin
                w_scOut   = w_addFull[WIDTH-1:0];
                w_scCarry = w_addFull[WIDTH];
                w_scOvf   = (A[WIDTH-1] == B[WIDTH-1]) && (w_addFull[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_scOut   = w_subFull[WIDTH-1:0];
                w_scCarry = w_subFull[WIDTH];
                w_scOvf   = (A[WIDTH-1] != B[WIDTH-1]) && (w_subFull[WIDTH-1] != A[WIDTH-1]);
            end
            OP_NOT: w_scOut = ~A;
            OP_EQ:  w_scOut = {{(WIDTH-1){1'b0}}, (A == B)};
            OP_SHL: w_scOut = A;
            OP_SHR: w_scOut = A;
            OP_SLT: w_scOut = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: w_scOut = '0;
        endcase
    end

    // Multiplier keeps {high, low} in r_acc with the multiplier shifting out of the low end.
    assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

    always_comb begin
        w_stepAcc   = w_mulNext;
        w_stepCarry = |w_mulNext[2*WIDTH-1:WIDTH];
        case (r_op)
            OP_SHL: begin
                w_stepAcc   = {{WIDTH{1'b0}}, r_acc[WIDTH-2:0], 1'b0};
                w_stepCarry = r_acc[WIDTH-1];
            end
            OP_SHR: begin
                w_stepAcc   = {{WIDTH{1'b0}}, 1'b0, r_acc[WIDTH-1:1]};
                w_stepCarry = r_acc[0];
            end
            default: ;
        endcase
    end

    assign w_finOut   = (r_state == S_BUSY) ? w_stepAcc[WIDTH-1:0] : w_scOut;
    assign w_finCarry = (r_state == S_BUSY) ? w_stepCarry : w_scCarry;
    assign w_finOvf   = (r_state == S_BUSY) ? 1'b0 : w_scOvf;

    // Control FSM; result and flags are written only on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_a        <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_out      <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_neg      <= 1'b0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op      <= control;
                        r_a       <= A;
                        r_inReady <= 1'b0;
                        if (w_startBusy) begin
                            r_state <= S_BUSY;
                            r_busy  <= 1'b1;
                            r_cnt   <= w_isShift ? CW'(w_shAmt) : CW'(WIDTH);
                            r_acc   <= {{WIDTH{1'b0}}, (w_isShift ? A : B)};
                        end else begin
                            r_state    <= S_DONE;
                            r_outValid <= 1'b1;
                            r_out      <= w_finOut;
                            r_zero     <= (w_finOut == '0);
                            r_carry    <= w_finCarry;
                            r_ovf      <= w_finOvf;
                            r_neg      <= w_finOut[WIDTH-1];
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_stepAcc;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_outValid <= 1'b1;
                        r_out      <= w_finOut;
                        r_zero     <= (w_finOut == '0);
                        r_carry    <= w_finCarry;
                        r_ovf      <= w_finOvf;
                        r_neg      <= w_finOut[WIDTH-1];
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state    <= S_IDLE;
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_inReady  <= 1'b1;
                    r_outValid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign busy      = r_busy;
    assign Out       = r_out;
    assign Zero      = r_zero;
    assign Carry     = r_carry;
    assign Overflow  = r_ovf;
    assign Negative  = r_neg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: a MUL-enabled instance plus a
// MUL_EN=0 instance for the illegal-multiply case.
module tb_alu_seq;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [3:0]       ctrl;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] result;
    logic             zeroF;
    logic             carryF;
    logic             ovfF;
    logic             negF;
    logic             busyF;

    logic             inValid0;
    logic             inReady0;
    logic [WIDTH-1:0] opA0;
    logic [WIDTH-1:0] opB0;
    logic [3:0]       ctrl0;
    logic             outValid0;
    logic [WIDTH-1:0] result0;
    logic             zeroF0;
    logic             carryF0;
    logic             ovfF0;
    logic             negF0;
    logic             busyF0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(WIDTH), .MUL_EN(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .A(opA), .B(opB), .control(ctrl), .out_valid(outValid),
        .out_ready(outReady), .Out(result), .Zero(zeroF), .Carry(carryF),
        .Overflow(ovfF), .Negative(negF), .busy(busyF)
    );

    alu_seq #(.WIDTH(WIDTH), .MUL_EN(0)) u_dutNoMul (
        .clk(clk), .rst(rst), .in_valid(inValid0), .in_ready(inReady0),
        .A(opA0), .B(opB0), .control(ctrl0), .out_valid(outValid0),
        .out_ready(1'b1), .Out(result0), .Zero(zeroF0), .Carry(carryF0),
        .Overflow(ovfF0), .Negative(negF0), .busy(busyF0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] expOut,
                               input logic expZ, input logic expC, input logic expV, input logic expN);
        check({tag, ".valid"}, 32'(outValid), 32'd1);
        check({tag, ".Out"}, 32'(result), 32'(expOut));
        check({tag, ".Zero"}, 32'(zeroF), 32'(expZ));
        check({tag, ".Carry"}, 32'(carryF), 32'(expC));
        check({tag, ".Overflow"}, 32'(ovfF), 32'(expV));
        check({tag, ".Negative"}, 32'(negF), 32'(expN));
    endtask

    // Presents one operation and returns 1ns after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        inValid = 1'b1;
        ctrl    = op;
        opA     = a;
        opB     = b;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic waitValid(input int limit, output int lat, output int busyCnt);
        lat     = 1;
        busyCnt = 0;
        while (!outValid && lat < limit) begin
            if (busyF) busyCnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finishOp(input string tag);
        @(posedge clk);
        #1;
        check({tag, ".validDrop"}, 32'(outValid), 32'd0);
        check({tag, ".readyBack"}, 32'(inReady), 32'd1);
    endtask

    task automatic doOp(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input int expLat, input logic [WIDTH-1:0] expOut,
                        input logic expZ, input logic expC, input logic expV, input logic expN);
        int lat;
        int busyCnt;
        applyStimulus(op, a, b);
        waitValid(40, lat, busyCnt);
        check({tag, ".latency"}, 32'(lat), 32'(expLat));
        check({tag, ".busyCycles"}, 32'(busyCnt), 32'(expLat - 1));
        checkOutput(tag, expOut, expZ, expC, expV, expN);
        finishOp(tag);
    endtask

    initial begin
        int seen;
        rst      = 1'b1;
        inValid  = 1'b1;
        ctrl     = 4'd2;
        opA      = 16'h0001;
        opB      = 16'h0001;
        outReady = 1'b1;
        inValid0 = 1'b0;
        ctrl0    = 4'd0;
        opA0     = '0;
        opB0     = '0;

        // Reset held with a pending request: nothing may be accepted.
        repeat (3) @(posedge clk);
        #1;
        check("reset.out_valid", 32'(outValid), 32'd0);
        check("reset.in_ready", 32'(inReady), 32'd1);
        check("reset.busy", 32'(busyF), 32'd0);
        check("reset.Out", 32'(result), 32'd0);
        check("reset.flags", {28'd0, zeroF, carryF, ovfF, negF}, 32'd0);
        @(negedge clk);
        inValid = 1'b0;
        rst     = 1'b0;
        @(posedge clk);
        #1;
        check("postReset.out_valid", 32'(outValid), 32'd0);

        doOp("add_ovf", 4'd2, 16'h7FFF, 16'h0001, 1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        doOp("sub_borrow", 4'd3, 16'h0003, 16'h0005, 1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b1);
        doOp("add_carry", 4'd2, 16'hFFFF, 16'hFFFF, 1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b1);
        doOp("and", 4'd0, 16'hF0F0, 16'hFF00, 1, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b1);
        doOp("or", 4'd1, 16'h0F00, 16'h00F0, 1, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        doOp("eq", 4'd5, 16'h1234, 16'h1234, 1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        doOp("shl4", 4'd6, 16'h8001, 16'h0004, 5, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
        doOp("shr1", 4'd7, 16'h0001, 16'h0001, 2, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        doOp("shl0", 4'd6, 16'h1234, 16'h0000, 1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        doOp("shlWrap", 4'd6, 16'h1234, 16'h0011, 2, 16'h2468, 1'b0, 1'b0, 1'b0, 1'b0);
        doOp("mulHigh", 4'd9, 16'h0100, 16'h0100, 17, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        doOp("mul3x5", 4'd9, 16'h0003, 16'h0005, 17, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
        doOp("not", 4'd4, 16'h00F0, 16'h0000, 1, 16'hFF0F, 1'b0, 1'b0, 1'b0, 1'b1);
        doOp("illegal12", 4'd12, 16'h0005, 16'h0003, 1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Backpressure: SLT result must hold while a second request is ignored.
        outReady = 1'b0;
        applyStimulus(4'd8, 16'hFFFF, 16'h0001);
        checkOutput("slt", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        inValid = 1'b1;
        ctrl    = 4'd2;
        opA     = 16'h0100;
        opB     = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp.Out", 32'(result), 32'h0001);
            check("bp.out_valid", 32'(outValid), 32'd1);
            check("bp.in_ready", 32'(inReady), 32'd0);
        end
        @(negedge clk);
        inValid  = 1'b0;
        outReady = 1'b1;
        finishOp("bp");
        check("bp.holdInIdle", 32'(result), 32'h0001);
        @(posedge clk);
        #1;
        check("bp.noQueuedOp", 32'(outValid), 32'd0);

        // Reset in the middle of a multiply discards it.
        applyStimulus(4'd9, 16'h0003, 16'h0005);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midReset.in_ready", 32'(inReady), 32'd1);
        check("midReset.busy", 32'(busyF), 32'd0);
        check("midReset.out_valid", 32'(outValid), 32'd0);
        check("midReset.Out", 32'(result), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (outValid) seen++;
        end
        check("midReset.neverValid", 32'(seen), 32'd0);

        // MUL_EN=0 instance: opcode 9 is illegal and completes in one cycle.
        @(negedge clk);
        inValid0 = 1'b1;
        ctrl0    = 4'd2;
        opA0     = 16'h0003;
        opB0     = 16'h0005;
        @(posedge clk);
        #1;
        inValid0 = 1'b0;
        check("noMul.add.valid", 32'(outValid0), 32'd1);
        check("noMul.add.Out", 32'(result0), 32'h0008);
        @(posedge clk);
        #1;
        @(negedge clk);
        inValid0 = 1'b1;
        ctrl0    = 4'd9;
        opA0     = 16'h0003;
        opB0     = 16'h0005;
        @(posedge clk);
        #1;
        inValid0 = 1'b0;
        check("noMul.mul.valid", 32'(outValid0), 32'd1);
        check("noMul.mul.busy", 32'(busyF0), 32'd0);
        check("noMul.mul.Out", 32'(result0), 32'h0000);
        check("noMul.mul.flags", {28'd0, zeroF0, carryF0, ovfF0, negF0}, 32'h8);
        check("noMul.mul.in_ready", 32'(inReady0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
